// File: rtl/vga_pkg.sv
// vga_pkg: shared raster timing constants for the VGA path.
// Holds the default 640x480@60 timing, the derived line/frame totals and
// sync window bounds, and the coordinate counter width used by every block
// that compares against h_cnt/v_cnt.
package vga_pkg;

    localparam int H_VISIBLE = 640;
    localparam int H_FRONT   = 16;
    localparam int H_SYNC    = 96;
    localparam int H_BACK    = 48;

    localparam int V_VISIBLE = 480;
    localparam int V_FRONT   = 10;
    localparam int V_SYNC    = 2;
    localparam int V_BACK    = 33;

    localparam int H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    // Sync windows are half-open: [START, END).
    localparam int HS_START = H_VISIBLE + H_FRONT;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_VISIBLE + V_FRONT;
    localparam int VS_END   = VS_START + V_SYNC;

    localparam int CNT_W = 10;

endpackage

// File: rtl/clk_en_div.sv
// clk_en_div: clock-enable divider.
// Counts 0..CLK_DIV-1 on every clk edge and raises tick during the cycle in
// which the count sits at CLK_DIV-1, so tick is a one-clk enable every
// CLK_DIV clocks. The first tick is seen on the CLK_DIV-th edge after reset
// is released.
//   clk  in  system clock
//   rst  in  synchronous active-high reset (count returns to 0)
//   tick out one-clk enable, decoded from the count register
module clk_en_div #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int DW = $clog2(CLK_DIV);

    if (CLK_DIV < 2) begin : g_bad_div
        $error("clk_en_div: CLK_DIV must be at least 2");
    end

    logic [DW-1:0] div;

    assign tick = (div == DW'(CLK_DIV - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            div <= '0;
        end else if (tick) begin
            div <= '0;
        end else begin
            div <= div + 1'b1;
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA raster timing generator.
// Advances the horizontal/vertical coordinate counters once per pixel
// enable and registers hsync, vsync, valid and the line/frame strobes from
// the coordinate being loaded, so every flag describes the h_cnt/v_cnt
// present in the same cycle.
//   clk         in  system clock
//   rst         in  synchronous active-high reset
//   pclk_en     out one-clk strobe: counters and flags just updated
//   h_cnt       out horizontal position, 0..H_TOTAL-1
//   v_cnt       out vertical position, 0..V_TOTAL-1
//   hsync       out horizontal sync, SYNC_ACTIVE level inside the window
//   vsync       out vertical sync, SYNC_ACTIVE level inside the window
//   valid       out current coordinate lies in the visible area
//   line_start  out one-clk strobe when h_cnt loads 0
//   frame_start out one-clk strobe when h_cnt and v_cnt both load 0
module vga_timing_gen #(
    parameter int   H_VISIBLE   = vga_pkg::H_VISIBLE,
    parameter int   H_FRONT     = vga_pkg::H_FRONT,
    parameter int   H_SYNC      = vga_pkg::H_SYNC,
    parameter int   H_BACK      = vga_pkg::H_BACK,
    parameter int   V_VISIBLE   = vga_pkg::V_VISIBLE,
    parameter int   V_FRONT     = vga_pkg::V_FRONT,
    parameter int   V_SYNC      = vga_pkg::V_SYNC,
    parameter int   V_BACK      = vga_pkg::V_BACK,
    parameter int   CLK_DIV     = 4,
    parameter logic SYNC_ACTIVE = 1'b0
) (
    input  logic                      clk,
    input  logic                      rst,
    output logic                      pclk_en,
    output logic [vga_pkg::CNT_W-1:0] h_cnt,
    output logic [vga_pkg::CNT_W-1:0] v_cnt,
    output logic                      hsync,
    output logic                      vsync,
    output logic                      valid,
    output logic                      line_start,
    output logic                      frame_start
);

    import vga_pkg::*;

    localparam int H_TOT = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOT = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int HS_LO = H_VISIBLE + H_FRONT;
    localparam int HS_HI = HS_LO + H_SYNC;
    localparam int VS_LO = V_VISIBLE + V_FRONT;
    localparam int VS_HI = VS_LO + V_SYNC;

    if (H_TOT > (1 << CNT_W)) begin : g_bad_h
        $error("vga_timing_gen: horizontal total exceeds counter range");
    end
    if (V_TOT > (1 << CNT_W)) begin : g_bad_v
        $error("vga_timing_gen: vertical total exceeds counter range");
    end

    logic             tick;
    logic [CNT_W-1:0] h_next;
    logic [CNT_W-1:0] v_next;
    logic             h_wrap;
    logic             hs_win;
    logic             vs_win;
    logic             vis;

    clk_en_div #(
        .CLK_DIV(CLK_DIV)
    ) u_div (
        .clk (clk),
        .rst (rst),
        .tick(tick)
    );

    // Next coordinate and the flags it implies; these are only loaded on a
    // tick so the registered flags always match the registered counters.
    // Upper window bounds can equal the counter range, hence the extra bit.
    always_comb begin
        h_wrap = (h_cnt == CNT_W'(H_TOT - 1));
        h_next = h_wrap ? '0 : h_cnt + 1'b1;
        v_next = v_cnt;
        if (h_wrap) begin
            v_next = (v_cnt == CNT_W'(V_TOT - 1)) ? '0 : v_cnt + 1'b1;
        end
        vis    = (h_next < CNT_W'(H_VISIBLE)) && (v_next < CNT_W'(V_VISIBLE));
        hs_win = (h_next >= CNT_W'(HS_LO)) &&
                 ({1'b0, h_next} < (CNT_W + 1)'(HS_HI));
        vs_win = (v_next >= CNT_W'(VS_LO)) &&
                 ({1'b0, v_next} < (CNT_W + 1)'(VS_HI));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            h_cnt       <= '0;
            v_cnt       <= '0;
            valid       <= 1'b0;
            hsync       <= ~SYNC_ACTIVE;
            vsync       <= ~SYNC_ACTIVE;
            pclk_en     <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else if (tick) begin
            h_cnt       <= h_next;
            v_cnt       <= v_next;
            valid       <= vis;
            hsync       <= hs_win ? SYNC_ACTIVE : ~SYNC_ACTIVE;
            vsync       <= vs_win ? SYNC_ACTIVE : ~SYNC_ACTIVE;
            pclk_en     <= 1'b1;
            line_start  <= (h_next == '0);
            frame_start <= (h_next == '0) && (v_next == '0);
        end else begin
            pclk_en     <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen. Three instances run side by side on one clock:
// the default 640x480 timing (CLK_DIV=4), a tiny 15x8 raster so frame wraps
// happen quickly, and the default raster with CLK_DIV=2 and active-high
// syncs. A model derives every output from the number of clocks since reset
// release; directed checks pin the model with hand-computed values.
module tb_vga_timing_gen;

    typedef struct packed {
        logic       pe;
        logic [9:0] h;
        logic [9:0] v;
        logic       hs;
        logic       vs;
        logic       valid;
        logic       ls;
        logic       fs;
    } obs_t;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_m = 1'b1;
    logic rst_s = 1'b1;
    logic rst_v = 1'b1;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUTs ----------------
    logic       pe0, hs0, vs0, va0, ls0, fs0;
    logic [9:0] h0, v0;
    logic       pe1, hs1, vs1, va1, ls1, fs1;
    logic [9:0] h1, v1;
    logic       pe2, hs2, vs2, va2, ls2, fs2;
    logic [9:0] h2, v2;

    vga_timing_gen u_main (
        .clk(clk), .rst(rst_m), .pclk_en(pe0), .h_cnt(h0), .v_cnt(v0),
        .hsync(hs0), .vsync(vs0), .valid(va0), .line_start(ls0),
        .frame_start(fs0)
    );

    vga_timing_gen #(
        .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
        .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1)
    ) u_small (
        .clk(clk), .rst(rst_s), .pclk_en(pe1), .h_cnt(h1), .v_cnt(v1),
        .hsync(hs1), .vsync(vs1), .valid(va1), .line_start(ls1),
        .frame_start(fs1)
    );

    vga_timing_gen #(
        .CLK_DIV(2), .SYNC_ACTIVE(1'b1)
    ) u_var (
        .clk(clk), .rst(rst_v), .pclk_en(pe2), .h_cnt(h2), .v_cnt(v2),
        .hsync(hs2), .vsync(vs2), .valid(va2), .line_start(ls2),
        .frame_start(fs2)
    );

    obs_t o [3];
    assign o[0] = {pe0, h0, v0, hs0, vs0, va0, ls0, fs0};
    assign o[1] = {pe1, h1, v1, hs1, vs1, va1, ls1, fs1};
    assign o[2] = {pe2, h2, v2, hs2, vs2, va2, ls2, fs2};

    // ---------------- check helper ----------------
    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)",
                     name, act, exp, $time);
        end
    endtask

    // ---------------- model ----------------
    // n = clock edges since the last edge that saw reset high. Pixel ticks
    // land on every d-th edge; the raster position is simply the tick count
    // modulo the frame size, split into column and row.
    function automatic obs_t model(input int n, hv, hf, hsw, hb,
                                   vv, vf, vsw, vb, d, input logic sa);
        obs_t r;
        int ht, vt, t, lin, h, v;
        ht = hv + hf + hsw + hb;
        vt = vv + vf + vsw + vb;
        t  = n / d;
        r  = '0;
        r.hs = ~sa;
        r.vs = ~sa;
        if (t > 0) begin
            lin = t % (ht * vt);
            h = lin % ht;
            v = lin / ht;
            r.h = h[9:0];
            r.v = v[9:0];
            r.valid = (h < hv) && (v < vv);
            if (h >= hv + hf && h < hv + hf + hsw) r.hs = sa;
            if (v >= vv + vf && v < vv + vf + vsw) r.vs = sa;
            r.pe = (n % d == 0);
            r.ls = r.pe && (h == 0);
            r.fs = r.ls && (v == 0);
        end
        return r;
    endfunction

    int n_m = 0, n_s = 0, n_v = 0;
    bit arm_m = 0, arm_s = 0, arm_v = 0;

    always @(posedge clk) begin
        n_m   <= rst_m ? 0 : n_m + 1;
        n_s   <= rst_s ? 0 : n_s + 1;
        n_v   <= rst_v ? 0 : n_v + 1;
        arm_m <= arm_m | rst_m;
        arm_s <= arm_s | rst_s;
        arm_v <= arm_v | rst_v;
    end

    // ---------------- scoreboard: every cycle ----------------
    always @(negedge clk) begin
        if (arm_m) check("main_raster", 32'(o[0]),
                         32'(model(n_m, 640, 16, 96, 48, 480, 10, 2, 33, 4, 1'b0)));
        if (arm_s) check("small_raster", 32'(o[1]),
                         32'(model(n_s, 8, 2, 3, 2, 4, 1, 2, 1, 4, 1'b0)));
        if (arm_v) check("var_raster", 32'(o[2]),
                         32'(model(n_v, 640, 16, 96, 48, 480, 10, 2, 33, 2, 1'b1)));
    end

    // ---------------- driver / wait tasks ----------------
    task automatic wait_pix(input int which, input int h, input int v,
                            input int budget);
        bit found = 0;
        for (int i = 0; i < budget && !found; i++) begin
            @(negedge clk);
            if (o[which].pe && o[which].h == h[9:0] && o[which].v == v[9:0])
                found = 1;
        end
        check($sformatf("reach_dut%0d_h%0d_v%0d", which, h, v),
              32'(found), 32'd1);
    endtask

    // Returns the number of negedges until the next pclk_en.
    task automatic wait_pe(input int which, input int budget, output int gap);
        gap = 0;
        do begin
            @(negedge clk);
            gap++;
        end while (!o[which].pe && gap < budget);
    endtask

    // ---------------- directed sequences ----------------
    task automatic seq_main();
        int gap, t0, cnt;
        // Tick spacing after the first pixel.
        for (int k = 0; k < 3; k++) begin
            wait_pe(0, 20, gap);
            check("main_pe_gap", 32'(gap), 32'd4);
        end
        // Visible edge and hsync window on line 0.
        wait_pix(0, 639, 0, 4000);
        check("main_valid_639", 32'(va0), 32'd1);
        wait_pix(0, 640, 0, 20);
        check("main_valid_640", 32'(va0), 32'd0);
        wait_pix(0, 655, 0, 100);
        check("main_hs_655", 32'(hs0), 32'd1);
        wait_pix(0, 656, 0, 20);
        check("main_hs_656", 32'(hs0), 32'd0);
        cnt = 0;
        while (hs0 == 1'b0 && cnt < 1000) begin
            cnt++;
            @(negedge clk);
        end
        check("main_hs_low_clks", 32'(cnt), 32'd384);
        check("main_hs_752_h", 32'(h0), 32'd752);
        check("main_hs_752", 32'(hs0), 32'd1);
        // Line strobe period.
        wait_pix(0, 0, 1, 4000);
        check("main_ls_line1", 32'(ls0), 32'd1);
        t0 = cyc;
        wait_pix(0, 0, 2, 4000);
        check("main_ls_period", 32'(cyc - t0), 32'd3200);
        // Line wrap 799,5 -> 0,6.
        wait_pix(0, 799, 5, 20000);
        wait_pe(0, 20, gap);
        check("main_wrap_h", 32'(h0), 32'd0);
        check("main_wrap_v", 32'(v0), 32'd6);
        check("main_wrap_ls", 32'(ls0), 32'd1);
        check("main_wrap_fs", 32'(fs0), 32'd0);
        @(negedge clk);
        check("main_ls_width", 32'(ls0), 32'd0);
        // Mid-line reset with the divider at 2.
        wait_pix(0, 300, 6, 4000);
        repeat (2) @(negedge clk);
        rst_m = 1'b1;
        @(negedge clk);
        check("main_mrst", 32'({pe0, h0, v0, hs0, vs0, va0, ls0, fs0}),
              32'({1'b0, 10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0}));
        rst_m = 1'b0;
        wait_pe(0, 20, gap);
        check("main_mrst_gap", 32'(gap), 32'd4);
        check("main_mrst_h", 32'(h0), 32'd1);
    endtask

    task automatic seq_small();
        int gap, t0;
        wait_pix(1, 14, 7, 1000);
        wait_pe(1, 20, gap);
        check("small_wrap", 32'({h1, v1, fs1, ls1, va1}),
              32'({10'd0, 10'd0, 1'b1, 1'b1, 1'b1}));
        t0 = cyc;
        wait_pix(1, 14, 4, 1000);
        check("small_vs_v4", 32'(vs1), 32'd1);
        wait_pix(1, 0, 5, 20);
        check("small_vs_v5", 32'(vs1), 32'd0);
        wait_pix(1, 14, 6, 200);
        check("small_vs_v6", 32'(vs1), 32'd0);
        wait_pix(1, 0, 7, 20);
        check("small_vs_v7", 32'(vs1), 32'd1);
        wait_pix(1, 0, 0, 1000);
        check("small_fs", 32'(fs1), 32'd1);
        check("small_fs_period", 32'(cyc - t0), 32'd480);
    endtask

    task automatic seq_var();
        int gap;
        for (int k = 0; k < 3; k++) begin
            wait_pe(2, 20, gap);
            check("var_pe_gap", 32'(gap), 32'd2);
        end
        check("var_h_after3", 32'(h2), 32'd3);
        wait_pix(2, 655, 0, 4000);
        check("var_hs_655", 32'(hs2), 32'd0);
        wait_pix(2, 656, 0, 20);
        check("var_hs_656", 32'(hs2), 32'd1);
        wait_pix(2, 751, 0, 400);
        check("var_hs_751", 32'(hs2), 32'd1);
        wait_pix(2, 752, 0, 20);
        check("var_hs_752", 32'(hs2), 32'd0);
    endtask

    // ---------------- main ----------------
    initial begin
        int gap;
        repeat (3) @(negedge clk);
        check("rst_main", 32'(o[0]),
              32'({1'b0, 10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0}));
        check("rst_small", 32'(o[1]),
              32'({1'b0, 10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0}));
        check("rst_var", 32'(o[2]),
              32'({1'b0, 10'd0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}));
        rst_m = 1'b0;
        rst_s = 1'b0;
        rst_v = 1'b0;
        fork
            begin
                wait_pe(0, 20, gap);
                check("main_first_gap", 32'(gap), 32'd4);
                check("main_first_pix", 32'({h0, v0, va0, ls0}),
                      32'({10'd1, 10'd0, 1'b1, 1'b0}));
                seq_main();
            end
            seq_small();
            seq_var();
        join
        repeat (4) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
